// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state encoding and default timeout for the APB master
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int TIMEOUT_CYCLES_DEF = 16;
endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus signals with master and slave views
interface apb_if #(parameter int ADDR_WIDTH = 4, parameter int DATA_WIDTH = 8);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;
  modport master (output PADDR, PSELx, PENABLE, PWRITE, PWDATA, input PREADY, PRDATA, PSLVERR);
  modport slave  (input PADDR, PSELx, PENABLE, PWRITE, PWDATA, output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_master.sv
// apb_master: single-command APB master with response handshake; optional ACCESS timeout under APB_MASTER_TIMEOUT_EN
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  apb_if.master                 apb
);
  state_t state;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  localparam bit unused_timeout = TIMEOUT_CYCLES > 0;
`endif
  assign cmd_ready = state == IDLE;
  // Transfer sequencer: every bus and response output is a flop updated alongside the state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      apb.PSELx   <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state      <= SETUP;
          apb.PSELx  <= 1'b1;
          apb.PADDR  <= cmd_addr;
          apb.PWRITE <= cmd_write;
          apb.PWDATA <= cmd_wdata;
        end
        SETUP: begin
          state       <= ACCESS;
          apb.PENABLE <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt         <= '0;
`endif
        end
        ACCESS: begin
          if (apb.PREADY) begin
            state       <= RESP;
            apb.PSELx   <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
            rsp_err     <= apb.PSLVERR;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= RESP;
            apb.PSELx   <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
          end else
            cnt <= cnt + CW'(1);
`endif
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table with scoreboard for apb_master, plus reset and timeout sequences
module tb_apb_master;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  apb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();
  apb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(bus)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    int         waits;
    logic       err_rdy;
    logic       err_wait;
    int         delay;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;
  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  vec_t vecs[7];
  exp_t sb[$];
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    n_vec++;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err});
    step();
    cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
    chk("setup_psel", bus.PSELx, 1);
    chk("setup_penable", bus.PENABLE, 0);
    chk("setup_paddr", bus.PADDR, v.addr);
    chk("setup_pwrite", bus.PWRITE, v.write);
    chk("busy_cmd_ready", cmd_ready, 0);
    step();
    for (int w = 0; w <= v.waits; w++) begin
      chk("access_psel", bus.PSELx, 1);
      chk("access_penable", bus.PENABLE, 1);
      chk("access_paddr", bus.PADDR, v.addr);
      chk("access_pwrite", bus.PWRITE, v.write);
      chk("access_pwdata", bus.PWDATA, v.wdata);
      chk("access_rsp_valid", rsp_valid, 0);
      bus.PREADY  = (w == v.waits);
      bus.PSLVERR = (w == v.waits) ? v.err_rdy : v.err_wait;
      bus.PRDATA  = (w == v.waits) ? v.prdata : 8'($urandom);
      step();
    end
    bus.PREADY = 0; bus.PSLVERR = 1'($urandom); bus.PRDATA = 8'($urandom);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel", bus.PSELx, 0);
    chk("resp_penable", bus.PENABLE, 0);
    for (int d = 0; d < v.delay; d++) begin
      rsp_ready = 0;
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, v.exp_rdata);
      chk("hold_err", rsp_err, v.exp_err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", bus.PSELx, 0);
    end
    rsp_ready = 1;
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_rdata", rsp_rdata, e.rdata);
      chk("sb_err", rsp_err, e.err);
    end
    step();
    rsp_ready = 0; cmd_valid = 0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_psel", bus.PSELx, 0);
  endtask
  initial begin
    vecs[0] = '{1'b1, 4'h2, 8'hA5, 8'h77, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 4'h3, 8'h00, 8'h5C, 2, 1'b0, 1'b0, 0, 8'h5C, 1'b0};
    vecs[2] = '{1'b1, 4'h7, 8'h3C, 8'h99, 0, 1'b1, 1'b0, 1, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 4'h1, 8'h11, 8'h42, 3, 1'b0, 1'b1, 0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 4'hF, 8'h00, 8'hC3, 1, 1'b0, 1'b0, 5, 8'hC3, 1'b0};
    vecs[5] = '{1'b0, 4'h8, 8'h00, 8'h00, 4, 1'b0, 1'b1, 2, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 4'h0, 8'h00, 8'hFF, 0, 1'b1, 1'b0, 0, 8'hFF, 1'b1};
    PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    bus.PREADY = 0; bus.PRDATA = 0; bus.PSLVERR = 0;
    step();
    step();
    PRESET = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", bus.PSELx, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h9; cmd_wdata = 8'h5A;
    step();
    cmd_valid = 0;
    step();
    step();
    chk("pre_rst_psel", bus.PSELx, 1);
    chk("pre_rst_penable", bus.PENABLE, 1);
    PRESET = 1;
    step();
    PRESET = 0;
    chk("mid_rst_psel", bus.PSELx, 0);
    chk("mid_rst_penable", bus.PENABLE, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_paddr", bus.PADDR, 0);
    chk("mid_rst_pwdata", bus.PWDATA, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_err", rsp_err, 0);
    run_vec(vecs[1]);
`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int t;
      n_vec++;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h4;
      bus.PREADY = 0; bus.PRDATA = 8'hEE;
      step();
      cmd_valid = 0;
      t = 1;
      while (!rsp_valid && t < 60) begin
        step();
        t++;
      end
      chk("to_latency", t, 18);
      chk("to_valid", rsp_valid, 1);
      chk("to_err", rsp_err, 1);
      chk("to_rdata", rsp_rdata, 0);
      chk("to_psel", bus.PSELx, 0);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("to_cmd_ready", cmd_ready, 1);
    end
`endif
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning the PADDR and cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the PWDATA, PRDATA, cmd_wdata and rsp_rdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum ACCESS cycles allowed before abort (used only with the timeout macro).
REQ-004 SHALL have ports as follows; one clock, reset synchronous and active-high:
- PCLK  in  1  sole clock, rising edge.
- PRESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  slave error or timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-006 cmd_ready SHALL be high only in IDLE; a command SHALL be accepted on a cycle with cmd_valid && cmd_ready.
REQ-007 On acceptance, the block SHALL register cmd_addr, cmd_write and cmd_wdata into PADDR, PWRITE and PWDATA and enter SETUP on the next cycle.
REQ-008 In SETUP, PSELx SHALL be 1 and PENABLE 0, and the next state SHALL be ACCESS unconditionally.
REQ-009 In ACCESS, PSELx and PENABLE SHALL be 1, and the block SHALL stay in ACCESS while PREADY is 0 (wait states).
REQ-010 On a cycle in ACCESS with PREADY high, the block SHALL capture PRDATA (reads only; 0 for writes) into rsp_rdata and PSLVERR into rsp_err, then enter RESP.
REQ-011 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-012 In RESP, rsp_valid SHALL be 1 with rsp_rdata and rsp_err held stable until rsp_ready; on rsp_valid && rsp_ready the next state SHALL be IDLE.
REQ-013 Latency SHALL be: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with zero wait states, plus one cycle per wait state.
REQ-014 Back-to-back throughput SHALL be one transfer per 4 cycles minimum; no second command SHALL be accepted while a response is pending.
REQ-015 PSELx and PENABLE SHALL be 0 in IDLE and RESP.
REQ-016 PSLVERR SHALL be ignored except on the PREADY-high ACCESS cycle.
REQ-017 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-018 PRESET high at a rising PCLK edge SHALL force state IDLE, and PSELx, PENABLE, PWRITE, rsp_valid and rsp_err to 0.
REQ-019 The same reset SHALL clear PADDR, PWDATA and rsp_rdata to 0, and the timeout counter to 0.
REQ-020 Reset mid-transfer (SETUP, ACCESS or RESP) SHALL abort it with no response issued; cmd_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-021 With macro APB_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY low.
REQ-022 With APB_MASTER_TIMEOUT_EN defined, after TIMEOUT_CYCLES such cycles the block SHALL drop PSELx and PENABLE, enter RESP with rsp_err=1 and rsp_rdata=0, and clear the counter on every SETUP.
REQ-023 Without APB_MASTER_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely for PREADY.

Structure
REQ-024 The state encoding typedef (IDLE/SETUP/ACCESS/RESP) and the default TIMEOUT_CYCLES constant SHALL reside in a shared package apb_pkg.
REQ-025 The block SHALL be a single module with no sub-module, connecting directly to apb_if PSELx/PENABLE/PREADY.

Verification
REQ-026 Write addr=0x2, data=0xA5, PREADY tied 1 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0x00.
REQ-027 Read addr=0x3 with PRDATA=0x5C and 2 wait states -> ACCESS held 3 cycles, PADDR stable, rsp_rdata=0x5C at cycle 5.
REQ-028 PSLVERR=1 on the PREADY cycle of a write -> rsp_err=1; PSLVERR=1 during wait states only -> rsp_err=0.
REQ-029 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> cmd_ready stays 0, rsp fields stable, new command accepted the cycle after handshake.
REQ-030 PRESET asserted during ACCESS -> next cycle PSELx=0, PENABLE=0, rsp_valid=0, cmd_ready=1.
REQ-031 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, PSELx=0.
